cond_flag_unit: RTL and testbench

//  Consumer end of the ALU status interface. Holds the architectural NZCV flag register and

---
 rtl/cond_flag_unit.sv | 154 +++++++++++++++
 tb/tb_cond_flag_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_unit.sv
// NZCV flag register, ARM condition evaluation and write-strobe gating for the single-cycle core.
// Optional executed/squashed statistics counters are built when COND_STATS_EN is defined.
module cond_flag_unit #(
    parameter int unsigned STAT_W   = 16,
    parameter logic [3:0]  FLAG_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [3:0]        cond,
    input  logic [1:0]        flag_w,
    input  logic [3:0]        alu_flags,
    input  logic              pcs,
    input  logic              reg_w,
    input  logic              mem_w,
    input  logic              no_write,
    output logic              pcs_g,
    output logic              reg_w_g,
    output logic              mem_w_g,
    output logic              cond_ex,
`ifdef COND_STATS_EN
    output logic [STAT_W-1:0] exec_cnt,
    output logic [STAT_W-1:0] squash_cnt,
    input  logic              stats_clr,
`endif
    output logic [3:0]        flags
);

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    if (STAT_W < 1 || STAT_W > 32) begin : g_bad_stat_w
        $error("cond_flag_unit: STAT_W must be within 1..32");
    end

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       ex;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Evaluated on the stored flags only, so an instruction never sees its own ALU result.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = flag_z;
            COND_NE: cond_ex = !flag_z;
            COND_CS: cond_ex = flag_c;
            COND_CC: cond_ex = !flag_c;
            COND_MI: cond_ex = flag_n;
            COND_PL: cond_ex = !flag_n;
            COND_VS: cond_ex = flag_v;
            COND_VC: cond_ex = !flag_v;
            COND_HI: cond_ex = flag_c && !flag_z;
            COND_LS: cond_ex = !flag_c || flag_z;
            COND_GE: cond_ex = (flag_n == flag_v);
            COND_LT: cond_ex = (flag_n != flag_v);
            COND_GT: cond_ex = !flag_z && (flag_n == flag_v);
            COND_LE: cond_ex = flag_z || (flag_n != flag_v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign ex      = instr_valid && cond_ex;
    assign pcs_g   = pcs && ex;
    assign reg_w_g = reg_w && ex && !no_write;
    assign mem_w_g = mem_w && ex;
    assign flags   = flags_q;

    // The two flag-write enables are independent: NZ and CV load separately.
    always_comb begin
        flags_d = flags_q;
        if (ex) begin
            if (flag_w[1]) begin
                flags_d[3:2] = alu_flags[3:2];
            end
            if (flag_w[0]) begin
                flags_d[1:0] = alu_flags[1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so all flops sample pre-edge values.
        if (rst) begin
            flags_q <= FLAG_RST;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef COND_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [STAT_W-1:0] exec_cnt_q;
    logic [STAT_W-1:0] exec_cnt_d;
    logic [STAT_W-1:0] squash_cnt_q;
    logic [STAT_W-1:0] squash_cnt_d;

    // Both counters saturate; a same-cycle clear beats any increment.
    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (stats_clr) begin
            exec_cnt_d   = '0;
            squash_cnt_d = '0;
        end else if (instr_valid) begin
            if (cond_ex) begin
                if (exec_cnt_q != STAT_MAX) begin
                    exec_cnt_d = exec_cnt_q + STAT_W'(1);
                end
            end else if (squash_cnt_q != STAT_MAX) begin
                squash_cnt_d = squash_cnt_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign exec_cnt   = exec_cnt_q;
    assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Randomised self-checking bench for cond_flag_unit against a flag/condition reference model.
// Statistics scenarios are compiled in only when COND_STATS_EN is defined.
module tb_cond_flag_unit;

    localparam int unsigned STAT_W   = 4;
    localparam int          STAT_MAX = (1 << STAT_W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic [3:0] cond;
    logic [1:0] flag_w;
    logic [3:0] alu_flags;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;
    logic       pcs_g;
    logic       reg_w_g;
    logic       mem_w_g;
    logic       cond_ex;
    logic [3:0] flags;
    logic       stats_clr;
`ifdef COND_STATS_EN
    logic [STAT_W-1:0] exec_cnt;
    logic [STAT_W-1:0] squash_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: individual flag bits and plain integer counters.
    bit m_n, m_z, m_c, m_v;
    int m_exec;
    int m_squash;

    cond_flag_unit #(
        .STAT_W  (STAT_W),
        .FLAG_RST(4'b0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .cond       (cond),
        .flag_w     (flag_w),
        .alu_flags  (alu_flags),
        .pcs        (pcs),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .no_write   (no_write),
        .pcs_g      (pcs_g),
        .reg_w_g    (reg_w_g),
        .mem_w_g    (mem_w_g),
        .cond_ex    (cond_ex),
`ifdef COND_STATS_EN
        .exec_cnt   (exec_cnt),
        .squash_cnt (squash_cnt),
        .stats_clr  (stats_clr),
`endif
        .flags      (flags)
    );

    always #5 clk = ~clk;

    function automatic bit model_cond(input logic [3:0] c);
        case (c)
            4'd0:    return m_z;
            4'd1:    return !m_z;
            4'd2:    return m_c;
            4'd3:    return !m_c;
            4'd4:    return m_n;
            4'd5:    return !m_n;
            4'd6:    return m_v;
            4'd7:    return !m_v;
            4'd8:    return m_c && !m_z;
            4'd9:    return !m_c || m_z;
            4'd10:   return m_n == m_v;
            4'd11:   return m_n != m_v;
            4'd12:   return !m_z && (m_n == m_v);
            4'd13:   return m_z || (m_n != m_v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] model_flags();
        return {m_n, m_z, m_c, m_v};
    endfunction

    task automatic drive(input bit v, input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                         input bit p, input bit r, input bit m, input bit nw);
        instr_valid = v;
        cond        = c;
        flag_w      = fw;
        alu_flags   = af;
        pcs         = p;
        reg_w       = r;
        mem_w       = m;
        no_write    = nw;
    endtask

    // One clock edge; the model advances using the inputs held across the edge.
    task automatic tick();
        bit ex;
        ex = instr_valid && model_cond(cond);
        @(posedge clk);
        if (rst) begin
            {m_n, m_z, m_c, m_v} = 4'b0000;
            m_exec   = 0;
            m_squash = 0;
        end else begin
            if (ex && flag_w[1]) {m_n, m_z} = alu_flags[3:2];
            if (ex && flag_w[0]) {m_c, m_v} = alu_flags[1:0];
            if (stats_clr) begin
                m_exec   = 0;
                m_squash = 0;
            end else if (instr_valid) begin
                if (model_cond(cond)) m_exec = (m_exec < STAT_MAX) ? m_exec + 1 : m_exec;
                else m_squash = (m_squash < STAT_MAX) ? m_squash + 1 : m_squash;
            end
        end
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        drive(1'b1, 4'b1110, 2'b11, f, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stats_clr = 1'b0;
        drive(1'b0, 4'b0001, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if (flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", flags);
        end
        checks++;
        if (cond_ex !== 1'b1) begin
            errors++;
            $display("FAIL reset_ne: cond_ex got %b expected 1", cond_ex);
        end
        cond = 4'b0000;
        #1;
        checks++;
        if (cond_ex !== 1'b0) begin
            errors++;
            $display("FAIL reset_eq: cond_ex got %b expected 0", cond_ex);
        end
`ifdef COND_STATS_EN
        checks++;
        if (exec_cnt !== '0 || squash_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", exec_cnt, squash_cnt);
        end
`endif
        rst = 1'b0;
        #1;
    endtask

    task automatic test_flag_load();
        load_flags(4'b0100);
        checks++;
        if (flags !== 4'b0100) begin
            errors++;
            $display("FAIL load_full: flags got %b expected 0100", flags);
        end
        drive(1'b1, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (cond_ex !== 1'b1) begin
            errors++;
            $display("FAIL load_eq_next: cond_ex got %b expected 1", cond_ex);
        end
        drive(1'b1, 4'b1110, 2'b01, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (flags !== 4'b0111) begin
            errors++;
            $display("FAIL load_cv_only: flags got %b expected 0111", flags);
        end
        drive(1'b1, 4'b1110, 2'b10, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (flags !== 4'b1011) begin
            errors++;
            $display("FAIL load_nz_only: flags got %b expected 1011", flags);
        end
    endtask

    task automatic test_squash();
        logic [3:0] sq_cond [3];
        bit         sq_val  [3];
        sq_cond = '{4'b0000, 4'b1111, 4'b1110};
        sq_val  = '{1'b1, 1'b1, 1'b0};
        load_flags(4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(sq_val[i], sq_cond[i], 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
            #1;
            checks++;
            if ({pcs_g, reg_w_g, mem_w_g} !== 3'b000) begin
                errors++;
                $display("FAIL squash_strobes[%0d]: got %b expected 000", i, {pcs_g, reg_w_g, mem_w_g});
            end
            tick();
            checks++;
            if (flags !== 4'b0000) begin
                errors++;
                $display("FAIL squash_flags[%0d]: got %b expected 0000", i, flags);
            end
        end
    endtask

    task automatic test_no_bypass();
        load_flags(4'b0100);
        drive(1'b1, 4'b0000, 2'b10, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if ({cond_ex, pcs_g, reg_w_g, mem_w_g} !== 4'b1101) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %b expected 1101", {cond_ex, pcs_g, reg_w_g, mem_w_g});
        end
        tick();
        #1;
        checks++;
        if (cond_ex !== 1'b0 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL bypass_next: cond_ex=%b flags=%b expected 0 0000", cond_ex, flags);
        end
    endtask

    task automatic test_cond_sweep();
        bit p, r, m, nw, exp_ex;
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            checks++;
            if (flags !== model_flags()) begin
                errors++;
                $display("FAIL sweep_load[%0d]: got %b expected %b", f, flags, model_flags());
            end
            for (int c = 0; c < 16; c++) begin
                p  = 1'($urandom);
                r  = 1'($urandom);
                m  = 1'($urandom);
                nw = 1'($urandom);
                drive(1'b1, 4'(c), 2'b00, 4'b0000, p, r, m, nw);
                #1;
                exp_ex = model_cond(4'(c));
                checks++;
                if ({cond_ex, pcs_g, reg_w_g, mem_w_g} !== {exp_ex, p && exp_ex, r && exp_ex && !nw, m && exp_ex}) begin
                    errors++;
                    $display("FAIL sweep f=%b c=%b: got %b expected %b", 4'(f), 4'(c),
                             {cond_ex, pcs_g, reg_w_g, mem_w_g},
                             {exp_ex, p && exp_ex, r && exp_ex && !nw, m && exp_ex});
                end
            end
        end
    endtask

    task automatic test_random();
        bit exp_ex;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) != 0), 4'($urandom), 2'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            stats_clr = ($urandom_range(31) == 0);
            #1;
            exp_ex = instr_valid && model_cond(cond);
            checks++;
            if ({flags, cond_ex, pcs_g, reg_w_g, mem_w_g} !==
                {model_flags(), model_cond(cond), pcs && exp_ex, reg_w && exp_ex && !no_write, mem_w && exp_ex}) begin
                errors++;
                $display("FAIL random[%0d]: flags/ex/strobes got %b expected %b", i,
                         {flags, cond_ex, pcs_g, reg_w_g, mem_w_g},
                         {model_flags(), model_cond(cond), pcs && exp_ex, reg_w && exp_ex && !no_write, mem_w && exp_ex});
            end
`ifdef COND_STATS_EN
            checks++;
            if (int'(exec_cnt) != m_exec || int'(squash_cnt) != m_squash) begin
                errors++;
                $display("FAIL random_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, exec_cnt, squash_cnt, m_exec, m_squash);
            end
`endif
            tick();
        end
        stats_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        load_flags(4'b1011);
        drive(1'b1, 4'b1110, 2'b11, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (flags !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_async: flags got %b expected 0000", flags);
        end
        tick();
        checks++;
        if (flags !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_edge: flags got %b expected 0000", flags);
        end
        rst = 1'b0;
        #1;
    endtask

`ifdef COND_STATS_EN
    task automatic test_stats();
        drive(1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i < 3) ? 4'b1110 : 4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (exec_cnt !== STAT_W'(3) || squash_cnt !== STAT_W'(2)) begin
            errors++;
            $display("FAIL stats_count: got %0d/%0d expected 3/2", exec_cnt, squash_cnt);
        end
        drive(1'b1, 4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < STAT_MAX + 4; i++) tick();
        checks++;
        if (int'(squash_cnt) != STAT_MAX || int'(squash_cnt) != m_squash) begin
            errors++;
            $display("FAIL stats_saturate: squash_cnt got %0d expected %0d", squash_cnt, STAT_MAX);
        end
        drive(1'b1, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        checks++;
        if (exec_cnt !== '0 || squash_cnt !== '0) begin
            errors++;
            $display("FAIL stats_clr_wins: got %0d/%0d expected 0/0", exec_cnt, squash_cnt);
        end
    endtask
`endif

    initial begin
        m_exec   = 0;
        m_squash = 0;
        #1;
        test_reset();
        test_flag_load();
        test_squash();
        test_no_bypass();
        test_cond_sweep();
        test_random();
        test_reset_mid();
`ifdef COND_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
